// File: rtl/mem_responder.sv
// mem_responder: unified word array answering read/write requests after a fixed wait
module mem_responder #(
   parameter int DEPTH   = 64,
   parameter int LATENCY = 2
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_mem_read,
   input  logic        i_mem_write,
   input  logic [31:0] i_addr,
   input  logic [31:0] i_wdata,
   output logic [31:0] o_rdata,
   output logic        o_ready,
   output logic        o_busy,
   output logic        o_err
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

   state_t        r_state;
   state_t        w_next;
   logic [3:0]    r_cnt;
   logic [31:0]   r_mem [DEPTH];
   logic [AW-1:0] r_idx;
   logic [31:0]   r_wdata;
   logic          r_write;
   logic          r_err;
   logic          w_idle;
   logic          w_req;
   logic          w_in_err;
   logic          w_commit;
   logic [AW-1:0] w_c_idx;
   logic [31:0]   w_c_wdata;
   logic          w_c_write;
   logic          w_c_err;

   assign w_idle   = r_state == IDLE;
   assign w_req    = i_mem_read | i_mem_write;
   assign w_in_err = (i_mem_read & i_mem_write) | (i_addr[1:0] != 2'b00)
                   | ({2'b00, i_addr[31:2]} >= 32'(DEPTH));
   assign w_commit = (r_state != DONE) && (w_next == DONE);

   // With zero latency the commit edge is also the latch edge, so the live request is used then
   assign w_c_idx   = w_idle ? i_addr[AW+1:2] : r_idx;
   assign w_c_wdata = w_idle ? i_wdata : r_wdata;
   assign w_c_write = w_idle ? i_mem_write : r_write;
   assign w_c_err   = w_idle ? w_in_err : r_err;

   // State register
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) r_state <= IDLE;
      else          r_state <= w_next;

   // Next state: IDLE -> WAIT/DONE on request, WAIT -> DONE when the counter runs out, DONE -> IDLE
   always_comb begin
      w_next = w_idle ? (w_req ? ((LATENCY > 0) ? WAIT : DONE) : IDLE)
             : (r_state == WAIT) ? ((r_cnt == 4'd0) ? DONE : WAIT)
             : IDLE;
   end

   // Outputs decoded from state; the error flag only shows during the completion cycle
   always_comb begin
      o_ready = r_state == DONE;
      o_busy  = !w_idle;
      o_err   = (r_state == DONE) & r_err;
   end

   // Request latch, wait counter, read data and array update; the array is never cleared
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) begin
         r_cnt   <= 4'd0;
         r_idx   <= '0;
         r_wdata <= 32'd0;
         r_write <= 1'b0;
         r_err   <= 1'b0;
         o_rdata <= 32'd0;
      end else begin
         if (w_idle && w_req) begin
            r_idx   <= i_addr[AW+1:2];
            r_wdata <= i_wdata;
            r_write <= i_mem_write;
            r_err   <= w_in_err;
            r_cnt   <= 4'(LATENCY - 1);
         end else if (r_state == WAIT && r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
         end
         if (w_commit && !w_c_err && w_c_write) r_mem[w_c_idx] <= w_c_wdata;
         if (w_commit && !w_c_err && !w_c_write) o_rdata <= r_mem[w_c_idx];
      end
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: randomized scoreboard bench for mem_responder against a cycle-count reference model
module tb_mem_responder;
   localparam int LAT = 2;
   localparam int DEP = 64;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        rd = 1'b0, wr = 1'b0;
   logic [31:0] addr = 32'd0, wdata = 32'd0;
   logic [31:0] rdata;
   logic        ready, busy, err;

   logic        z_rd = 1'b0, z_wr = 1'b0;
   logic [31:0] z_addr = 32'd0, z_wdata = 32'd0;
   logic [31:0] z_rdata;
   logic        z_ready, z_busy, z_err;

   int compared = 0;
   int mismatched = 0;

   always #5 clk = ~clk;

   mem_responder #(.DEPTH(DEP), .LATENCY(LAT)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_mem_read(rd), .i_mem_write(wr),
      .i_addr(addr), .i_wdata(wdata), .o_rdata(rdata), .o_ready(ready),
      .o_busy(busy), .o_err(err)
   );

   mem_responder #(.DEPTH(DEP), .LATENCY(0)) dut0 (
      .i_clk(clk), .i_rst_n(rst_n), .i_mem_read(z_rd), .i_mem_write(z_wr),
      .i_addr(z_addr), .i_wdata(z_wdata), .o_rdata(z_rdata), .o_ready(z_ready),
      .o_busy(z_busy), .o_err(z_err)
   );

   typedef struct {int cyc; logic err;} exp_t;
   exp_t sb[$];

   logic [31:0] m_mem [DEP];
   logic [31:0] m_rdata = 32'd0;
   int          cyc = 0;
   int          free = 0;
   bit          p_valid = 1'b0;
   int          p_ready = 0;
   int          p_idx = 0;
   logic        p_wr = 1'b0, p_err = 1'b0;
   logic [31:0] p_wdata = 32'd0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
      end
   endtask

   // Reference model: a request seen while free is accepted, completes LAT+1 cycles later,
   // and takes effect on the edge just before completion unless reset intervenes
   always @(posedge clk) begin
      if (!rst_n) begin
         p_valid = 1'b0;
         free    = 0;
         m_rdata = 32'd0;
      end else begin
         if (cyc >= free && (rd || wr)) begin
            p_valid = 1'b1;
            p_ready = cyc + LAT + 1;
            free    = cyc + LAT + 2;
            p_wr    = wr;
            p_idx   = int'(addr >> 2);
            p_wdata = wdata;
            p_err   = (rd && wr) || addr[1:0] != 2'b00 || (addr >> 2) >= DEP;
         end
         if (p_valid && cyc == p_ready - 1) begin
            p_valid = 1'b0;
            if (!p_err) begin
               if (p_wr) m_mem[p_idx] = p_wdata;
               else      m_rdata = m_mem[p_idx];
            end
            sb.push_back('{p_ready, p_err});
         end
      end
      cyc++;
   end

   // Monitor: every cycle checks busy and read data; completions are matched against the scoreboard
   always @(negedge clk) begin
      logic due;
      due = sb.size() != 0 && sb[0].cyc <= cyc;
      chk("busy", 32'(busy), 32'(cyc < free));
      chk("rdata", rdata, m_rdata);
      chk("ready", 32'(ready), 32'(due));
      if (ready && sb.size() != 0) begin
         chk("ready_cycle", 32'(cyc), 32'(sb[0].cyc));
         chk("err", 32'(err), 32'(sb[0].err));
         void'(sb.pop_front());
      end else begin
         if (due) void'(sb.pop_front());
         chk("err_idle", 32'(err), 32'(ready));
      end
   end

   // Zero-latency instance: completion in the cycle right after the request
   initial begin
      wait (rst_n === 1'b1);
      @(negedge clk);
      z_wr = 1'b1; z_addr = 32'h10; z_wdata = 32'hDEADBEEF;
      @(negedge clk);
      z_wr = 1'b0;
      chk("l0_wr_ready", 32'(z_ready), 32'd1);
      chk("l0_wr_busy", 32'(z_busy), 32'd1);
      @(negedge clk);
      chk("l0_idle_ready", 32'(z_ready), 32'd0);
      chk("l0_idle_busy", 32'(z_busy), 32'd0);
      z_rd = 1'b1;
      @(negedge clk);
      z_rd = 1'b0;
      chk("l0_rd_ready", 32'(z_ready), 32'd1);
      chk("l0_rd_busy", 32'(z_busy), 32'd1);
      chk("l0_rd_err", 32'(z_err), 32'd0);
      chk("l0_rdata", z_rdata, 32'hDEADBEEF);
      @(negedge clk);
      chk("l0_after_busy", 32'(z_busy), 32'd0);
   end

   task automatic issue(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
      rd = r; wr = w; addr = a; wdata = d;
      @(negedge clk);
      rd = 1'b0; wr = 1'b0;
      repeat (LAT + 2) @(negedge clk);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_ready", 32'(ready), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_rdata", rdata, 32'd0);
      // Preload every word with the write request held high: back-to-back accesses
      for (int i = 0; i < DEP; i++) begin
         wr = 1'b1; addr = 32'(i * 4); wdata = $urandom;
         if (i == 0) #2 rst_n = 1'b1;
         repeat (LAT + 2) @(negedge clk);
      end
      wr = 1'b0;
      // Random traffic, changing every cycle so many requests land while busy
      for (int k = 0; k < 800; k++) begin
         int s, e;
         s = $urandom_range(0, 15);
         e = $urandom_range(0, 19);
         rd = s < 7;
         wr = s >= 7 && s < 12;
         addr = 32'($urandom_range(0, DEP - 1)) << 2;
         wdata = $urandom;
         if (e == 0) begin rd = 1'b1; wr = 1'b1; end
         if (e == 1) addr = addr | 32'($urandom_range(1, 3));
         if (e == 2) addr = 32'($urandom_range(DEP, 1 << 20)) << 2;
         @(negedge clk);
      end
      rd = 1'b0; wr = 1'b0;
      repeat (LAT + 3) @(negedge clk);
      // Directed accesses and error requests
      issue(1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
      issue(1'b1, 1'b0, 32'h10, 32'h0);
      issue(1'b1, 1'b1, 32'h10, 32'h11111111);
      issue(1'b0, 1'b1, 32'h12, 32'h22222222);
      issue(1'b0, 1'b1, 32'h100, 32'h33333333);
      issue(1'b1, 1'b0, 32'h12, 32'h0);
      issue(1'b1, 1'b0, 32'h10, 32'h0);
      // Second request pulsed in cycle 1 of a busy access
      wr = 1'b1; addr = 32'h14; wdata = 32'hA5A5A5A5;
      @(negedge clk);
      wr = 1'b0; rd = 1'b1; addr = 32'h18;
      @(negedge clk);
      rd = 1'b0;
      repeat (LAT + 2) @(negedge clk);
      issue(1'b1, 1'b0, 32'h14, 32'h0);
      // Reset in the middle of a write's wait
      wr = 1'b1; addr = 32'h20; wdata = 32'h12345678;
      @(negedge clk);
      wr = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_ready", 32'(ready), 32'd0);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_err", 32'(err), 32'd0);
      chk("mid_rst_rdata", rdata, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rd = 1'b1; addr = 32'h20;
      #2 rst_n = 1'b1;
      @(negedge clk);
      rd = 1'b0;
      repeat (LAT + 3) @(negedge clk);
      chk("sb_drained", 32'(sb.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter DEPTH, 64, number of 32-bit words in the unified instruction/data array.
REQ-002 Parameter LATENCY, 2, wait cycles inserted before each access completes (legal range 0..15).
REQ-003 Port i_clk  input  1  clock; all state changes on the rising edge.
REQ-004 Port i_rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port i_mem_read  input  1  read request level from the control FSM.
REQ-006 Port i_mem_write  input  1  write request level from the control FSM.
REQ-007 Port i_addr  input  32  byte address; the word index is i_addr[31:2].
REQ-008 Port i_wdata  input  32  write data.
REQ-009 Port o_rdata  output  32  registered read data.
REQ-010 Port o_ready  output  1  one-cycle completion pulse.
REQ-011 Port o_busy  output  1  high whenever the state is not IDLE.
REQ-012 Port o_err  output  1  one-cycle error pulse, coincident with o_ready.

Function
REQ-013 States SHALL be IDLE, WAIT and DONE, held in a registered state variable.
REQ-014 In IDLE, i_mem_read or i_mem_write high SHALL latch i_addr, i_wdata and the request type at the clock edge.
REQ-015 From IDLE, the next state SHALL be WAIT if LATENCY>0, otherwise DONE.
REQ-016 On entry to WAIT, a 4-bit counter SHALL load LATENCY-1, decrement each cycle, and the state SHALL move to DONE on the edge where the counter equals 0.
REQ-017 The access SHALL commit on the edge entering DONE: a write updates the array, and a read loads o_rdata from the latched word index.
REQ-018 In DONE, o_ready SHALL be 1 for exactly one cycle, and the next state SHALL be IDLE unconditionally.
REQ-019 Latency: with the request first seen in cycle 0, o_ready SHALL be high in cycle LATENCY+1.
REQ-020 Requests arriving while o_busy=1 SHALL be ignored; no queueing.
REQ-021 A request still high in the IDLE cycle after DONE SHALL be accepted as a new request.
REQ-022 i_mem_read and i_mem_write high together SHALL be an error request.
REQ-023 i_addr[1:0]!=0 SHALL be an error request.
REQ-024 A word index >= DEPTH SHALL be an error request.
REQ-025 An error request SHALL follow the same state timing as a valid request, assert o_err together with o_ready, write nothing, and leave o_rdata unchanged.
REQ-026 o_rdata SHALL hold its value until the next successful read completes.
REQ-027 Changes on the inputs after the latch edge SHALL NOT affect the access in progress.

Reset
REQ-028 Reset SHALL force state IDLE, counter 0, o_rdata 0, o_ready 0, o_busy 0 and o_err 0.
REQ-029 Array contents SHALL NOT be cleared by reset.
REQ-030 Reset asserted before the DONE-entry edge SHALL abort the access with no array write and no o_ready pulse.
REQ-031 After reset deassertion, the first request SHALL be accepted in the first IDLE cycle.

Verification
REQ-032 Write then read, LATENCY=2: write 0xDEADBEEF to addr 0x10, then read addr 0x10 -> o_ready in cycle 3 for each access, o_rdata=0xDEADBEEF, o_err=0.
REQ-033 LATENCY=0: read addr 0x10 -> o_ready in cycle 1; o_busy high in cycle 1 only.
REQ-034 Error cases: read and write together, addr 0x12, and addr 0x100 with DEPTH=64 -> each gives o_ready+o_err in cycle LATENCY+1, the array is unchanged, and o_rdata keeps its prior value.
REQ-035 A second request pulsed in cycle 1 of a busy access -> ignored; exactly one o_ready pulse.
REQ-036 Reset mid-WAIT of a write of 0x12345678 to addr 0x20 -> outputs 0 immediately; a later read of 0x20 returns the old value.
REQ-037 Request held high continuously -> back-to-back accesses with o_ready every LATENCY+2 cycles.
